// File: rtl/mem_tp_bit_rmw.sv
// mem_tp_bit_rmw
//   Two-port memory: bit-wise write enable on port A, ready/valid read on
//   port B. Storage is byte-enable granular; fully enabled bytes commit in
//   one cycle, while a write containing any partially enabled byte runs a
//   read-modify-write sequence (IDLE -> RMW_RD -> RMW_WR -> IDLE).
//
//   Optional feature macro: MEM_WRITE_FWD_EN
//     defined     : write-first on a same-cycle, same-address collision
//     not defined : read-first, no forwarding mux
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-low reset
//   ena          port A write request
//   a_ready      port A can accept a request this cycle
//   wea          bit-wise write enable
//   addra        write address
//   dina         write data
//   enb          port B read request
//   b_ready      port B can accept a request this cycle
//   addrb        read address
//   doutb        read data (held between reads)
//   doutb_valid  one-cycle pulse when doutb carries new read data
module mem_tp_bit_rmw #(
    parameter string MEM_TYPE      = "auto",
    parameter int    MEM_DATAWIDTH = 128,
    parameter int    MEM_ADDRWIDTH = 14,
    parameter int    READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ena,
    output logic                     a_ready,
    input  logic [MEM_DATAWIDTH-1:0] wea,
    input  logic [MEM_ADDRWIDTH-1:0] addra,
    input  logic [MEM_DATAWIDTH-1:0] dina,
    input  logic                     enb,
    output logic                     b_ready,
    input  logic [MEM_ADDRWIDTH-1:0] addrb,
    output logic [MEM_DATAWIDTH-1:0] doutb,
    output logic                     doutb_valid
);

    localparam int NB    = (MEM_DATAWIDTH + 7) / 8;
    localparam int PW    = NB * 8;
    localparam int DEPTH = 1 << MEM_ADDRWIDTH;

    // Valid-bit mask of the padded word; padding bits are ignored when
    // classifying the top byte, which makes them "equal to the valid bits".
    localparam logic [PW-1:0] VMASK = PW'({MEM_DATAWIDTH{1'b1}});

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("mem_tp_bit_rmw: READ_LATENCY must be 1 or 2");
    end

    if (MEM_TYPE != "auto" && MEM_TYPE != "block" && MEM_TYPE != "ultra") begin : g_bad_type
        $error("mem_tp_bit_rmw: MEM_TYPE must be auto, block or ultra");
    end

    typedef enum logic [1:0] {
        IDLE,
        RMW_RD,
        RMW_WR
    } state_t;

    state_t state, state_next;

    logic [PW-1:0] mem [DEPTH];

    function automatic logic [NB-1:0] byte_any(input logic [PW-1:0] w);
        logic [NB-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            r[i] = |w[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] byte_full(input logic [PW-1:0] w);
        logic [NB-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            r[i] = &(w[i*8 +: 8] | ~VMASK[i*8 +: 8]);
        end
        return r;
    endfunction

    logic [NB-1:0] wea_any, wea_full;
    logic          has_partial;
    logic          a_acc, b_acc, a_full_wr;

    always_comb begin
        wea_any     = byte_any(PW'(wea));
        wea_full    = byte_full(PW'(wea));
        has_partial = |(wea_any & ~wea_full);
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            IDLE: begin
                a_ready = 1'b1;
                b_ready = 1'b1;
                if (ena && has_partial) begin
                    state_next = RMW_RD;
                end
            end
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_acc     = ena & a_ready & reset;
        b_acc     = enb & b_ready & reset;
        a_full_wr = a_acc & ~has_partial;
    end

    // ------------------------------------------------- RMW request latch
    logic [MEM_ADDRWIDTH-1:0] lat_addr;
    logic [MEM_DATAWIDTH-1:0] lat_din;
    logic [MEM_DATAWIDTH-1:0] lat_wea;
    logic [MEM_DATAWIDTH-1:0] rmw_old;
    logic [MEM_DATAWIDTH-1:0] merged;

    // Single array read port shared between port B and the RMW read; the
    // FSM holds b_ready low in RMW_RD so the two never compete.
    logic [MEM_ADDRWIDTH-1:0] rd_addr;
    logic [PW-1:0]            rd_pad;
    logic [MEM_DATAWIDTH-1:0] rd_word;
    logic [MEM_DATAWIDTH-1:0] rd_ret;

    always_comb begin
        rd_addr = (state == RMW_RD) ? lat_addr : addrb;
        rd_pad  = mem[rd_addr];
        rd_word = rd_pad[MEM_DATAWIDTH-1:0];
        merged  = (rmw_old & ~lat_wea) | (lat_din & lat_wea);
    end

    always_ff @(posedge clk) begin
        if (a_acc && has_partial) begin
            lat_addr <= addra;
            lat_din  <= dina;
            lat_wea  <= wea;
        end
        if (state == RMW_RD) begin
            rmw_old <= rd_word;
        end
    end

    // --------------------------------------------------------- write port
    logic [MEM_ADDRWIDTH-1:0] wr_addr;
    logic [PW-1:0]            wr_pad;
    logic [NB-1:0]            byte_we;

    always_comb begin
        wr_addr = addra;
        wr_pad  = PW'(dina);
        byte_we = '0;
        if (state == RMW_WR) begin
            wr_addr = lat_addr;
            wr_pad  = PW'(merged);
            byte_we = byte_any(PW'(lat_wea));
        end else if (a_full_wr) begin
            byte_we = wea_full;
        end
        // Reset aborts an in-flight RMW before its commit edge.
        if (!reset) begin
            byte_we = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (byte_we[i]) begin
                mem[wr_addr][i*8 +: 8] <= wr_pad[i*8 +: 8];
            end
        end
    end

    // ----------------------------------------------- collision handling
`ifdef MEM_WRITE_FWD_EN
    logic collide;
    always_comb begin
        collide = b_acc & a_full_wr & (addra == addrb);
        rd_ret  = collide ? ((rd_word & ~wea) | (dina & wea)) : rd_word;
    end
`else
    always_comb begin
        rd_ret = rd_word;
    end
`endif

    // ------------------------------------------------------ read pipeline
    if (READ_LATENCY == 2) begin : g_rl2
        logic [MEM_DATAWIDTH-1:0] s1_data;
        logic                     s1_valid;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_data     <= '0;
                s1_valid    <= 1'b0;
                doutb       <= '0;
                doutb_valid <= 1'b0;
            end else begin
                s1_valid    <= b_acc;
                doutb_valid <= s1_valid;
                if (b_acc) begin
                    s1_data <= rd_ret;
                end
                if (s1_valid) begin
                    doutb <= s1_data;
                end
            end
        end
    end else begin : g_rl1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                doutb       <= '0;
                doutb_valid <= 1'b0;
            end else begin
                doutb_valid <= b_acc;
                if (b_acc) begin
                    doutb <= rd_ret;
                end
            end
        end
    end

endmodule

// File: doc/mem_tp_bit_rmw.md
Name: mem_tp_bit_rmw

Overview:
- Successor two-port memory with bit-wise write enable on port A and read on port B.
- Storage is byte-enable granular (FPGA block/ultra RAM or chip SRAM).
- Exact bit-mask semantics: full-byte writes commit in one cycle; partial-byte writes go through an internal read-modify-write (RMW) sequence.
- Port B adds a ready/valid read path with configurable read latency, and collision behaviour is defined.

Parameters:
- MEM_TYPE, "auto": FPGA storage kind: auto, block, ultra. Distributed is not supported.
- MEM_DATAWIDTH, 128: word width in bits, 8..1024. Need not be a multiple of 8.
- MEM_ADDRWIDTH, 14: address width. Depth = 2^MEM_ADDRWIDTH.
- READ_LATENCY, 1: port B read latency in cycles. Only 1 or 2 are legal; other values trigger an elaboration error.

Ports:
- clk  input  1  single clock
- reset  input  1  asynchronous, active-low reset
- ena  input  1  port A write request
- a_ready  output  1  port A can accept a request this cycle
- wea  input  MEM_DATAWIDTH  bit-wise write enable
- addra  input  MEM_ADDRWIDTH  write address
- dina  input  MEM_DATAWIDTH  write data
- enb  input  1  port B read request
- b_ready  output  1  port B can accept a request this cycle
- addrb  input  MEM_ADDRWIDTH  read address
- doutb  output  MEM_DATAWIDTH  read data
- doutb_valid  output  1  one-cycle pulse when doutb carries new read data

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, a_ready=1, b_ready=1, doutb=0, doutb_valid=0, read pipeline cleared.
  - Array contents are not reset.
  - Reset asserted during RMW aborts the sequence; no array write is committed.
- a_ready and b_ready are decoded from registered state only. There is no combinational path from any input.
- Accept rules:
  - Port A accepts on ena & a_ready.
  - Port B accepts on enb & b_ready.
  - Requests issued while not ready are ignored. The requester holds the request and retries.
- Byte classification (wea zero-padded to a multiple of 8):
  - A byte is "full" if all its wea bits are 1, "empty" if all are 0, otherwise "partial".
  - Padding bits count as equal to the byte's valid bits.
- Accepted write with no partial byte:
  - Array byte-write of the full bytes in the same cycle.
  - Empty bytes are untouched. wea=0 is an accepted no-op.
  - a_ready stays 1; back-to-back writes run at 1 per cycle.
- Accepted write with at least one partial byte. FSM IDLE -> RMW_RD -> RMW_WR -> IDLE:
  - IDLE, accept cycle: latch addra, dina, wea. Nothing is written. Port B may still be accepted this cycle.
  - RMW_RD: a_ready=0, b_ready=0. Internal read of the latched address is issued on the array read port.
  - RMW_WR: a_ready=0, b_ready=0. Merge: new = (old & ~wea) | (dina & wea). Write all bytes with any wea bit set.
  - Return to IDLE with a_ready=1 and b_ready=1. Throughput is 3 cycles per partial write.
- Read:
  - Request accepted at cycle t gives doutb and doutb_valid=1 at cycle t+READ_LATENCY.
  - doutb holds its last value otherwise.
  - With READ_LATENCY=2 the second stage is an output register.
  - Internal RMW reads never raise doutb_valid and never change doutb.
- Collision (port B read accepted in the same cycle as a full-byte array write to the same address): read-first; port B returns old data.
- Writes and reads to different addresses are independent.

Optional Feature:
- Macro: MEM_WRITE_FWD_EN.
- Defined: write-first on collision. The returned data is (old & ~wea) | (dina & wea) for the colliding full-byte write.
- Forwarding applies only to single-cycle writes. RMW commits occur while b_ready=0, so they never collide.
- Not defined: read-first, as above. No forwarding mux is built.

Test Plan:
- Full-word write, READ_LATENCY=1: write wea=all-1, addr 0x10, dina=0xA5..A5; read addr 0x10 next cycle -> doutb=0xA5..A5, doutb_valid one cycle later, a_ready never drops.
- Partial-bit RMW:
  - Preload 0xFF..FF at addr 3, then write wea=0x0F (bits 0-3), dina=0.
  - Expect a_ready=0 and b_ready=0 for exactly 2 cycles.
  - A later read returns 0xFF..F0, with untouched bytes intact.
- Back-to-back mixed traffic:
  - Sequence: full write, partial write, full write on consecutive attempts.
  - The second full write is accepted exactly 3 cycles after the partial write.
  - A read held during the stall is accepted when b_ready returns, and all data is correct.
- Collision: same-cycle full write 0x11..11 over 0x22..22 at addr 5 with read of addr 5 -> doutb=0x22..22 (macro off), 0x11..11 (MEM_WRITE_FWD_EN).
- Reset mid-RMW:
  - Assert reset during RMW_RD.
  - Outputs go to their reset values immediately, and the addressed word is unchanged.
  - a_ready=1 after release.
- READ_LATENCY=2, MEM_DATAWIDTH=36:
  - Read accepted at t gives doutb_valid at t+2.
  - A partial write with wea=0xF00000000 (top nibble, padded byte) is handled as full-byte in one cycle.
